// File: rtl/puf_pkg.sv
// Shared types and default constants for the ring-oscillator PUF measurement path.
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_GATE    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } puf_state_t;

    localparam int unsigned PUF_CNT_W  = 8;
    localparam int unsigned PUF_SEL_W  = 5;
    localparam int unsigned PUF_WINDOW = 256;
    localparam int unsigned PUF_SETTLE = 4;
    localparam int unsigned PUF_N_BITS = 8;

endpackage

// File: rtl/puf_gate_timer.sv
// Loadable down-counter with zero flag; times the gate window and settle wait.
module puf_gate_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] value;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/puf_meas_seq.sv
// Measurement sequencer: per challenge bit clears the counters, gates the
// oscillators, waits for settling, then compares the two counts into the response.
module puf_meas_seq
    import puf_pkg::*;
#(
    parameter int unsigned CNT_W  = PUF_CNT_W,
    parameter int unsigned SEL_W  = PUF_SEL_W,
    parameter int unsigned N_BITS = PUF_N_BITS,
    parameter int unsigned WINDOW = PUF_WINDOW,
    parameter int unsigned SETTLE = PUF_SETTLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [SEL_W-1:0]  challenge,
    input  logic [CNT_W-1:0]  cnt_a,
    input  logic [CNT_W-1:0]  cnt_b,
    output logic              ro_en,
    output logic              cnt_clr,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic              resp_valid,
    output logic [N_BITS-1:0] response,
    output logic              tie,
    output logic              sat
);

    localparam int unsigned TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned BW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [TW-1:0] WIN_LD  = TW'(WINDOW - 1);
    localparam logic [TW-1:0] SET_LD  = TW'(SETTLE - 1);
    localparam logic [BW-1:0] LAST_IX = BW'(N_BITS - 1);

    puf_state_t       state, state_nx;
    logic [SEL_W-1:0] base;
    logic [BW-1:0]    bit_idx;
    logic             t_load, t_dec, t_zero;
    logic [TW-1:0]    t_ld_val;
    logic             aborting;

    assign aborting = abort && (state != ST_IDLE);

    puf_gate_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_ld_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    always_comb begin
        state_nx = state;
        t_load   = 1'b0;
        t_ld_val = '0;
        t_dec    = 1'b0;
        unique case (state)
            ST_IDLE:    if (start) state_nx = ST_CLEAR;
            ST_CLEAR: begin
                t_load   = 1'b1;
                t_ld_val = WIN_LD;
                state_nx = ST_GATE;
            end
            ST_GATE: begin
                if (t_zero) begin
                    t_load   = 1'b1;
                    t_ld_val = SET_LD;
                    state_nx = ST_SETTLE;
                end else begin
                    t_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (t_zero) state_nx = ST_COMPARE;
                else        t_dec    = 1'b1;
            end
            ST_COMPARE: state_nx = (bit_idx == LAST_IX) ? ST_DONE : ST_CLEAR;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
        if (aborting) state_nx = ST_IDLE;
    end

    // Strobes are registered from the current state, so they trail it by one cycle;
    // an abort zeroes them on the same edge so nothing leaks after the cancel.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            ro_en      <= 1'b0;
            cnt_clr    <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            sel        <= '0;
            response   <= '0;
            tie        <= 1'b0;
            sat        <= 1'b0;
            bit_idx    <= '0;
            base       <= '0;
        end else begin
            state <= state_nx;
            if (aborting) begin
                ro_en      <= 1'b0;
                cnt_clr    <= 1'b0;
                busy       <= 1'b0;
                resp_valid <= 1'b0;
                response   <= '0;
            end else begin
                ro_en      <= (state == ST_GATE);
                cnt_clr    <= (state == ST_CLEAR);
                busy       <= (state != ST_IDLE);
                resp_valid <= (state == ST_DONE);
                if (state == ST_CLEAR) sel <= base + SEL_W'(bit_idx);
                if (state == ST_IDLE && start) begin
                    base     <= challenge;
                    bit_idx  <= '0;
                    response <= '0;
                    tie      <= 1'b0;
                    sat      <= 1'b0;
                end
                if (state == ST_COMPARE) begin
                    response[bit_idx] <= (cnt_a > cnt_b);
                    if (cnt_a == cnt_b) tie <= 1'b1;
                    if ((cnt_a == '1) || (cnt_b == '1)) sat <= 1'b1;
                    if (bit_idx != LAST_IX) bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_meas_seq.sv
// Directed bench for puf_meas_seq with WINDOW=16, SETTLE=2, N_BITS=4 (period 20).
module tb_puf_meas_seq;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [4:0] challenge;
    logic [7:0] cnt_a, cnt_b;
    logic       ro_en, cnt_clr, busy, resp_valid, tie, sat;
    logic [4:0] sel;
    logic [3:0] response;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    puf_meas_seq #(
        .CNT_W  (8),
        .SEL_W  (5),
        .N_BITS (4),
        .WINDOW (16),
        .SETTLE (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .challenge  (challenge),
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b),
        .ro_en      (ro_en),
        .cnt_clr    (cnt_clr),
        .sel        (sel),
        .busy       (busy),
        .resp_valid (resp_valid),
        .response   (response),
        .tie        (tie),
        .sat        (sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " ro_en"}, 32'(ro_en), 32'd0);
        chk({tag, " cnt_clr"}, 32'(cnt_clr), 32'd0);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    endtask

    // Edge 0 accepts start; after edge c the bank counts for bit (c-1)/20 are presented,
    // so the COMPARE of bit i (sampled at edge 20i+20) sees ca[i]/cb[i].
    task automatic run(input logic [4:0] base, input logic [3:0][7:0] ca,
                       input logic [3:0][7:0] cb, input logic noise, input logic ab0,
                       input logic [3:0] er, input logic et, input logic es);
        int unsigned b;
        logic [4:0]  exp_sel;
        challenge = base; start = 1'b1; abort = ab0;
        tick();
        start = 1'b0; abort = 1'b0;
        for (int c = 1; c <= 84; c++) begin
            b = (c - 1) / 20;
            if (b > 3) b = 3;
            cnt_a = ca[b];
            cnt_b = cb[b];
            if (noise && (c == 10 || c == 50)) begin
                start = 1'b1; challenge = ~base;
            end else begin
                start = 1'b0; challenge = base;
            end
            tick();
            chk("busy", 32'(busy), 32'(c <= 81));
            chk("cnt_clr", 32'(cnt_clr), 32'(c <= 80 && (c % 20) == 1));
            chk("ro_en", 32'(ro_en), 32'(c <= 80 && (c % 20) >= 2 && (c % 20) <= 17));
            chk("resp_valid", 32'(resp_valid), 32'(c == 81));
            exp_sel = base + 5'(b);
            chk("sel", 32'(sel), 32'(exp_sel));
            if (c == 1) begin
                chk("response cleared", 32'(response), 32'd0);
                chk("tie cleared", 32'(tie), 32'd0);
                chk("sat cleared", 32'(sat), 32'd0);
            end
            if (c == 81) begin
                chk("response", 32'(response), 32'(er));
                chk("tie", 32'(tie), 32'(et));
                chk("sat", 32'(sat), 32'(es));
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        challenge = '0; cnt_a = '0; cnt_b = '0;
        tick();
        tick();
        rst_n = 1'b0;
        chk_idle("reset");
        chk("reset sel", 32'(sel), 32'd0);
        chk("reset response", 32'(response), 32'd0);
        chk("reset tie", 32'(tie), 32'd0);
        chk("reset sat", 32'(sat), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("idle abort");

        run(5'd5, {8'd40, 8'd40, 8'd40, 8'd40}, {8'd30, 8'd30, 8'd30, 8'd30},
            1'b0, 1'b0, 4'b1111, 1'b0, 1'b0);
        run(5'd3, {8'd20, 8'd60, 8'd10, 8'd90}, {8'd20, 8'd50, 8'd70, 8'd80},
            1'b0, 1'b0, 4'b0101, 1'b1, 1'b0);
        run(5'd31, {8'd5, 8'd5, 8'd5, 8'd255}, {8'd6, 8'd6, 8'd6, 8'd100},
            1'b0, 1'b0, 4'b0001, 1'b0, 1'b1);

        // Abort during GATE of bit 2 (state GATE over cycles 41..56).
        challenge = 5'd2; cnt_a = 8'd50; cnt_b = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 44; c++) tick();
        chk("pre-abort response", 32'(response), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort");
        chk("abort response", 32'(response), 32'd0);
        for (int c = 0; c < 40; c++) begin
            tick();
            chk_idle("post-abort");
        end

        // Start with abort in the same IDLE cycle, plus starts while busy.
        run(5'd9, {8'd30, 8'd30, 8'd30, 8'd30}, {8'd40, 8'd40, 8'd40, 8'd40},
            1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);

        // Synchronous reset sampled while in SETTLE of bit 1 (cycles 37..38).
        challenge = 5'd7; cnt_a = 8'd90; cnt_b = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 37; c++) tick();
        chk("pre-reset sel", 32'(sel), 32'd8);
        chk("pre-reset response", 32'(response), 32'd1);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk_idle("mid reset");
        chk("mid reset sel", 32'(sel), 32'd0);
        chk("mid reset response", 32'(response), 32'd0);
        chk("mid reset tie", 32'(tie), 32'd0);
        chk("mid reset sat", 32'(sat), 32'd0);
        for (int c = 0; c < 30; c++) begin
            tick();
            chk_idle("post-reset");
        end

        run(5'd0, {8'd255, 8'd255, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd255, 8'd255},
            1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_meas_seq.md
Name: puf_meas_seq

Overview:
Measurement sequencer for the ring-oscillator PUF.
- Walks a sequence of challenges, one per response bit.
- For each challenge it drives the mux select and clears the two oscillator counter banks, then gates the oscillators for a fixed window and lets the counters settle.
- It then compares the two counts and shifts the result into a response word.
- It sits between the host (ui_in/uo_out glue) and the two oscillator/mux/counter banks and comparator path.

Parameters:
CNT_W, 8, width of each oscillator count input
SEL_W, 5, width of the challenge/mux select
N_BITS, 8, response bits produced per evaluation
WINDOW, 256, clk cycles the oscillators are enabled per bit (>=1)
SETTLE, 4, clk cycles waited after the gate closes before sampling counts (>=1)

Ports:
clk  in  1  system clock (the only clock)
rst_n  in  1  synchronous, active-high reset despite the name
start  in  1  single-cycle request to begin an evaluation
abort  in  1  cancel the evaluation in progress
challenge  in  SEL_W  base challenge, latched on an accepted start
cnt_a  in  CNT_W  count from oscillator bank A
cnt_b  in  CNT_W  count from oscillator bank B
ro_en  out  1  oscillator enable (the ena to both banks)
cnt_clr  out  1  counter clear pulse to both banks
sel  out  SEL_W  mux select to both banks
busy  out  1  high from CLEAR through DONE
resp_valid  out  1  one-cycle pulse when response is complete
response  out  N_BITS  response word
tie  out  1  sticky: some bit had cnt_a == cnt_b
sat  out  1  sticky: some sampled count was all-ones

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-high.
- Reset (rst_n=1 at a clk edge) sets:
  - state = IDLE
  - ro_en = 0, cnt_clr = 0, busy = 0, resp_valid = 0
  - sel = 0, response = 0, tie = 0, sat = 0
  - bit_idx = 0, timer = 0
- Reset takes precedence over start and abort.
- States: IDLE, CLEAR, GATE, SETTLE, COMPARE, DONE.
- IDLE:
  - If start=1, latch challenge into base, set bit_idx=0, clear response, tie and sat, and go to CLEAR.
  - start is ignored in every other state.
- CLEAR (1 cycle):
  - cnt_clr = 1, ro_en = 0.
  - sel = base + bit_idx, truncated to SEL_W bits (wraps mod 2^SEL_W).
  - Load timer = WINDOW-1, then go to GATE.
- GATE (exactly WINDOW cycles):
  - ro_en = 1; timer counts down.
  - At timer==0, load timer = SETTLE-1 and go to SETTLE.
- SETTLE (exactly SETTLE cycles):
  - ro_en = 0; sel is held so the counters see a stable mux.
  - At timer==0, go to COMPARE.
- COMPARE (1 cycle):
  - Sample cnt_a/cnt_b and set response[bit_idx] = (cnt_a > cnt_b), unsigned compare.
  - Equal counts give 0 and set tie.
  - If either count equals 2^CNT_W-1, set sat.
  - If bit_idx == N_BITS-1 go to DONE; else increment bit_idx and go to CLEAR.
- DONE (1 cycle):
  - resp_valid = 1, then go to IDLE.
  - response, tie and sat hold until the next accepted start or reset.
- Timing:
  - ro_en, cnt_clr, sel, busy and resp_valid are registered Moore outputs.
  - Per-bit period P = WINDOW+SETTLE+2 cycles.
  - With start sampled at edge 0, busy first reads 1 after edge 1.
  - resp_valid is high during cycle N_BITS*P+1.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, with ro_en = 0, cnt_clr = 0, busy = 0.
  - response is cleared to 0; resp_valid is never asserted for the aborted run.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- ro_en must never be 1 in the same cycle as cnt_clr.
- ro_en must never be 1 outside GATE.

Decomposition:
- Package puf_pkg holds:
  - the state enum (puf_state_t) and its 3-bit encoding
  - default parameter constants (PUF_CNT_W, PUF_SEL_W, PUF_WINDOW, PUF_SETTLE, PUF_N_BITS)
- One sub-module, puf_gate_timer: a loadable down-counter with a zero flag, sized clog2(max(WINDOW,SETTLE)).
- The FSM, bit index and response register stay in puf_meas_seq.

Test Plan:
All scenarios use WINDOW=16, SETTLE=2, N_BITS=4, so P=20.
1. Basic run: challenge=5, start at cycle 0, cnt_a=40 / cnt_b=30 during every COMPARE.
   -> sel is 5, 6, 7, 8 across the four CLEARs.
   -> ro_en is high for 16 consecutive cycles per bit.
   -> resp_valid pulses at cycle 81 with response=4'b1111, tie=0, sat=0.
2. Mixed bits: cnt_a > cnt_b on bits 0 and 2 only, cnt_a < cnt_b on bit 1, cnt_a == cnt_b on bit 3.
   -> response=4'b0101, tie=1.
3. Wrap and saturation: challenge=31, with cnt_a=255 on bit 0.
   -> sel sequence is 31, 0, 1, 2.
   -> sat=1 and response[0]=1 (given cnt_b<255).
4. Abort mid-run: assert abort during the GATE of bit 2.
   -> next cycle busy=0, ro_en=0, response=0.
   -> no resp_valid pulse; a new start after that runs a full 81-cycle sequence.
5. Start while busy: pulse start at cycles 10 and 50 with a different challenge.
   -> both are ignored; sel follows the original base and resp_valid stays at cycle 81.
6. Synchronous reset mid-run: rst_n=1 for one cycle during SETTLE.
   -> all outputs take their reset values at the next edge; no cnt_clr and no ro_en until the next start.
